// File: rtl/conv1d_pe_row.sv
// Time-multiplexed 1-D convolution PE row: one kernel tap per cycle across all output lanes.
// Optional ReLU clamp on the result copy is enabled by defining CAE_PE_RELU_EN.
module conv1d_pe_row #(
    parameter int DATA_WIDTH  = 8,
    parameter int INPUT_SIZE  = 8,
    parameter int KERNEL_SIZE = 3,
    parameter int ACC_WIDTH   = 2*DATA_WIDTH,
    localparam int OUT_SIZE   = INPUT_SIZE-KERNEL_SIZE+1
) (
    input  logic                                   clk_i,
    input  logic                                   rst,
    input  logic                                   en,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [INPUT_SIZE-1:0][DATA_WIDTH-1:0]  data_in,
    input  logic [KERNEL_SIZE-1:0][DATA_WIDTH-1:0] weight_in,
    input  logic [OUT_SIZE-1:0][ACC_WIDTH-1:0]     psum_in,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [OUT_SIZE-1:0][ACC_WIDTH-1:0]     psum_out,
    output logic                                   busy,
    output logic                                   done
);

    // state  | meaning
    // S_IDLE | waiting for a job, in_ready high
    // S_MAC  | taps 0..K-1 accumulate; at tap==K the result is copied out
    // S_OUT  | result held on psum_out until out_ready
    typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

    localparam int TAP_W = $clog2(KERNEL_SIZE+1);
    localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(KERNEL_SIZE);

    state_t                                 state_q, state_d;
    logic [TAP_W-1:0]                       tap_q, tap_d, tap_sel;
    logic [INPUT_SIZE-1:0][DATA_WIDTH-1:0]  data_q, data_d;
    logic [KERNEL_SIZE-1:0][DATA_WIDTH-1:0] weight_q, weight_d;
    logic [OUT_SIZE-1:0][ACC_WIDTH-1:0]     acc_q, acc_d, psum_q, psum_d;
    logic [OUT_SIZE-1:0][ACC_WIDTH-1:0]     mac, res;
    logic signed [DATA_WIDTH-1:0]           w_sel;

    // The copy cycle (tap==K) has no valid tap; steer the index to 0 to stay in range.
    assign tap_sel = (tap_q == TAP_LAST) ? '0 : tap_q;
    assign w_sel   = $signed(weight_q[tap_sel]);

    for (genvar j = 0; j < OUT_SIZE; j++) begin : g_lane
        logic signed [DATA_WIDTH-1:0]   d_sel;
        logic signed [2*DATA_WIDTH-1:0] prod;
        assign d_sel  = $signed(data_q[j + int'(tap_sel)]);
        assign prod   = (2*DATA_WIDTH)'(d_sel) * (2*DATA_WIDTH)'(w_sel);
        assign mac[j] = acc_q[j] + ACC_WIDTH'(prod);
`ifdef CAE_PE_RELU_EN
        assign res[j] = acc_q[j][ACC_WIDTH-1] ? '0 : acc_q[j];
`else
        assign res[j] = acc_q[j];
`endif
    end

    always_comb begin
        state_d  = state_q;
        tap_d    = tap_q;
        data_d   = data_q;
        weight_d = weight_q;
        acc_d    = acc_q;
        psum_d   = psum_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    data_d   = data_in;
                    weight_d = weight_in;
                    acc_d    = psum_in;
                    tap_d    = '0;
                    state_d  = S_MAC;
                end
            end
            S_MAC: begin
                if (tap_q == TAP_LAST) begin
                    psum_d  = res;
                    state_d = S_OUT;
                end else begin
                    acc_d = mac;
                    tap_d = tap_q + 1'b1;
                end
            end
            S_OUT: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            tap_q    <= '0;
            data_q   <= '0;
            weight_q <= '0;
            acc_q    <= '0;
            psum_q   <= '0;
        end else if (en) begin
            state_q  <= state_d;
            tap_q    <= tap_d;
            data_q   <= data_d;
            weight_q <= weight_d;
            acc_q    <= acc_d;
            psum_q   <= psum_d;
        end
    end

    // in_ready is gated by reset so every output reads 0 while rst is asserted.
    assign in_ready  = rst && (state_q == S_IDLE);
    assign out_valid = (state_q == S_OUT);
    assign busy      = (state_q == S_MAC) || (state_q == S_OUT);
    assign done      = en && out_ready && (state_q == S_OUT);
    assign psum_out  = psum_q;

endmodule
